// File: rtl/load_pkg.sv
// Shared encodings and helpers for the load alignment unit.
// Holds the funct3 load types, FSM states, lane-offset width and legality check.
package load_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMem  = 2'b01,
        StResp = 2'b10
    } state_e;

    function automatic int unsigned off_width(input int unsigned xlen);
        return $clog2(xlen / 8);
    endfunction

    // High when the load type is illegal for this XLEN or the address is misaligned for it.
    function automatic logic load_err(input logic [2:0] f3, input logic [2:0] addr_lo,
                                      input logic is64);
        logic err;
        case (f3)
            F3_LB, F3_LBU: err = 1'b0;
            F3_LH, F3_LHU: err = addr_lo[0];
            F3_LW:         err = |addr_lo[1:0];
            F3_LWU:        err = !is64 || (|addr_lo[1:0]);
            F3_LD:         err = !is64 || (|addr_lo);
            default:       err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane select and sign/zero extension of a memory read word.
// The lane is shifted down to bit 0 and then extended according to funct3.
module load_extract
    import load_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned OFF_W = 2
) (
    input  logic [XLEN-1:0]  rdata_i,
    input  logic [OFF_W-1:0] offset_i,
    input  logic [2:0]       funct3_i,
    output logic [XLEN-1:0]  data_o
);

    logic [63:0] lane;
    logic [63:0] res;

    // Work in 64 bits so the same extension code serves both XLEN values.
    always_comb begin
        lane = 64'(rdata_i >> {offset_i, 3'b000});
        res  = '0;
        case (funct3_i)
            F3_LB:   res = {{56{lane[7]}}, lane[7:0]};
            F3_LH:   res = {{48{lane[15]}}, lane[15:0]};
            F3_LW:   res = {{32{lane[31]}}, lane[31:0]};
            F3_LD:   res = lane;
            F3_LBU:  res = {56'b0, lane[7:0]};
            F3_LHU:  res = {48'b0, lane[15:0]};
            F3_LWU:  res = {32'b0, lane[31:0]};
            default: res = '0;
        endcase
        data_o = XLEN'(res);
    end

endmodule

// File: rtl/load_align_unit.sv
// Load unit between MEM stage and data memory: one request in flight, variable-latency ack,
// lane extraction, misalign/illegal and timeout reporting, result held until consumed.
module load_align_unit
    import load_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Req_valid,
    output logic            Req_ready,
    input  logic [XLEN-1:0] Req_addr,
    input  logic [2:0]      Req_funct3,
    output logic            Mem_req,
    output logic [XLEN-1:0] Mem_addr,
    input  logic            Mem_ack,
    input  logic [XLEN-1:0] Mem_rdata,
    output logic            Load_valid,
    input  logic            Load_ack,
    output logic [XLEN-1:0] Load_data,
    output logic            Misaligned,
    output logic            Timeout_err
);

    localparam int unsigned OFF_W = off_width(XLEN);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic IS64 = (XLEN == 64);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [OFF_W-1:0] off_q;
    logic [2:0]       f3_q;
    logic [XLEN-1:0]  ext_data;

    load_extract #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_extract (
        .rdata_i  (Mem_rdata),
        .offset_i (off_q),
        .funct3_i (f3_q),
        .data_o   (ext_data)
    );

    assign Req_ready = (state_q == StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            off_q       <= '0;
            f3_q        <= '0;
            Mem_req     <= 1'b0;
            Mem_addr    <= '0;
            Load_valid  <= 1'b0;
            Load_data   <= '0;
            Misaligned  <= 1'b0;
            Timeout_err <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (Req_valid) begin
                        off_q <= Req_addr[OFF_W-1:0];
                        f3_q  <= Req_funct3;
                        cnt_q <= '0;
                        if (load_err(Req_funct3, Req_addr[2:0], IS64)) begin
                            Misaligned <= 1'b1;
                            Load_valid <= 1'b1;
                            Load_data  <= '0;
                            state_q    <= StResp;
                        end else begin
                            Mem_req  <= 1'b1;
                            Mem_addr <= {Req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                            state_q  <= StMem;
                        end
                    end
                end
                StMem: begin
                    // An ack arriving in the final allowed cycle still completes the load.
                    if (Mem_ack) begin
                        Load_data  <= ext_data;
                        Mem_req    <= 1'b0;
                        Load_valid <= 1'b1;
                        state_q    <= StResp;
                    end else if (cnt_q == CNT_LAST) begin
                        Timeout_err <= 1'b1;
                        Load_data   <= '0;
                        Mem_req     <= 1'b0;
                        Load_valid  <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    if (Load_ack) begin
                        Load_valid  <= 1'b0;
                        Load_data   <= '0;
                        Misaligned  <= 1'b0;
                        Timeout_err <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: an XLEN=32 and an XLEN=64 instance, both TIMEOUT_CYCLES=4,
// selected by sel64 and observed through a common set of muxed signals.
module tb_load_align_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        sel64, req_valid, mem_ack, load_ack;
    logic [63:0] addr, rdata;
    logic [2:0]  f3;

    logic        rr32, mr32, lv32, mis32, to32;
    logic [31:0] ma32, ld32;
    logic        rr64, mr64, lv64, mis64, to64;
    logic [63:0] ma64, ld64;

    logic        o_rr, o_mr, o_lv, o_mis, o_to;
    logic [63:0] o_ma, o_ld;

    int checks = 0;
    int errors = 0;

    load_align_unit #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut32 (
        .clk         (clk),
        .rst         (rst),
        .Req_valid   (req_valid & ~sel64),
        .Req_ready   (rr32),
        .Req_addr    (addr[31:0]),
        .Req_funct3  (f3),
        .Mem_req     (mr32),
        .Mem_addr    (ma32),
        .Mem_ack     (mem_ack),
        .Mem_rdata   (rdata[31:0]),
        .Load_valid  (lv32),
        .Load_ack    (load_ack),
        .Load_data   (ld32),
        .Misaligned  (mis32),
        .Timeout_err (to32)
    );

    load_align_unit #(.XLEN(64), .TIMEOUT_CYCLES(4)) dut64 (
        .clk         (clk),
        .rst         (rst),
        .Req_valid   (req_valid & sel64),
        .Req_ready   (rr64),
        .Req_addr    (addr),
        .Req_funct3  (f3),
        .Mem_req     (mr64),
        .Mem_addr    (ma64),
        .Mem_ack     (mem_ack),
        .Mem_rdata   (rdata),
        .Load_valid  (lv64),
        .Load_ack    (load_ack),
        .Load_data   (ld64),
        .Misaligned  (mis64),
        .Timeout_err (to64)
    );

    assign o_rr  = sel64 ? rr64  : rr32;
    assign o_mr  = sel64 ? mr64  : mr32;
    assign o_lv  = sel64 ? lv64  : lv32;
    assign o_mis = sel64 ? mis64 : mis32;
    assign o_to  = sel64 ? to64  : to32;
    assign o_ma  = sel64 ? ma64  : {32'b0, ma32};
    assign o_ld  = sel64 ? ld64  : {32'b0, ld32};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [63:0] a, input logic [2:0] f, input logic ack);
        req_valid = 1'b1;
        addr      = a;
        f3        = f;
        mem_ack   = ack;
        step();
        req_valid = 1'b0;
    endtask

    task automatic release_resp(input string tag);
        mem_ack  = 1'b0;
        load_ack = 1'b1;
        step();
        load_ack = 1'b0;
        chk({tag, "_lv_clr"}, {63'b0, o_lv}, 64'd0);
        chk({tag, "_rdy_back"}, {63'b0, o_rr}, 64'd1);
    endtask

    task automatic zero_wait(input string tag, input logic [63:0] a, input logic [2:0] f,
                             input logic [63:0] exp);
        logic [63:0] mask;
        mask = sel64 ? 64'h7 : 64'h3;
        accept(a, f, 1'b1);
        chk({tag, "_mreq"}, {63'b0, o_mr}, 64'd1);
        chk({tag, "_maddr"}, o_ma, a & ~mask);
        chk({tag, "_lv_early"}, {63'b0, o_lv}, 64'd0);
        step();
        chk({tag, "_lv"}, {63'b0, o_lv}, 64'd1);
        chk({tag, "_data"}, o_ld, exp);
        chk({tag, "_flags"}, {62'b0, o_mis, o_to}, 64'd0);
        chk({tag, "_mreq_off"}, {63'b0, o_mr}, 64'd0);
        release_resp(tag);
    endtask

    task automatic mis_check(input string tag, input logic [63:0] a, input logic [2:0] f);
        accept(a, f, 1'b0);
        chk({tag, "_lv"}, {63'b0, o_lv}, 64'd1);
        chk({tag, "_mis"}, {63'b0, o_mis}, 64'd1);
        chk({tag, "_data"}, o_ld, 64'd0);
        chk({tag, "_mreq"}, {63'b0, o_mr}, 64'd0);
        chk({tag, "_to"}, {63'b0, o_to}, 64'd0);
        release_resp(tag);
        chk({tag, "_mis_clr"}, {63'b0, o_mis}, 64'd0);
    endtask

    initial begin
        sel64     = 1'b0;
        req_valid = 1'b0;
        mem_ack   = 1'b0;
        load_ack  = 1'b0;
        addr      = '0;
        f3        = '0;
        rdata     = 64'hFEDCBA98_A14BC5F3;
        rst       = 1'b1;
        #12;
        rst = 1'b0;

        chk("rst_ready", {63'b0, o_rr}, 64'd1);
        chk("rst_mreq", {63'b0, o_mr}, 64'd0);
        chk("rst_maddr", o_ma, 64'd0);
        chk("rst_lv", {63'b0, o_lv}, 64'd0);
        chk("rst_data", o_ld, 64'd0);
        chk("rst_flags", {62'b0, o_mis, o_to}, 64'd0);
        step();

        zero_wait("lb101", 64'h101, 3'b000, 64'h0000_0000_FFFF_FFC5);
        zero_wait("lbu103", 64'h103, 3'b100, 64'h0000_0000_0000_00A1);
        zero_wait("lh102", 64'h102, 3'b001, 64'h0000_0000_FFFF_A14B);
        zero_wait("lhu100", 64'h100, 3'b101, 64'h0000_0000_0000_C5F3);
        zero_wait("lw100", 64'h100, 3'b010, 64'h0000_0000_A14B_C5F3);

        mis_check("lw105", 64'h105, 3'b010);
        mis_check("lh101", 64'h101, 3'b001);
        mis_check("ld32", 64'h100, 3'b011);

        // Ack withheld three cycles: Mem_req seen high for four cycles total.
        accept(64'h100, 3'b010, 1'b0);
        chk("wait_mreq0", {63'b0, o_mr}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_mreq", {63'b0, o_mr}, 64'd1);
            chk("wait_lv", {63'b0, o_lv}, 64'd0);
        end
        mem_ack = 1'b1;
        step();
        chk("wait_lv_set", {63'b0, o_lv}, 64'd1);
        chk("wait_data", o_ld, 64'h0000_0000_A14B_C5F3);
        chk("wait_to", {63'b0, o_to}, 64'd0);
        release_resp("wait");

        // No ack at all: timeout after four MEM cycles.
        accept(64'h100, 3'b010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_mreq", {63'b0, o_mr}, 64'd1);
            chk("to_lv", {63'b0, o_lv}, 64'd0);
        end
        step();
        chk("to_lv_set", {63'b0, o_lv}, 64'd1);
        chk("to_err", {63'b0, o_to}, 64'd1);
        chk("to_data", o_ld, 64'd0);
        chk("to_mreq_off", {63'b0, o_mr}, 64'd0);
        chk("to_mis", {63'b0, o_mis}, 64'd0);
        release_resp("to");
        chk("to_err_clr", {63'b0, o_to}, 64'd0);

        // Consumer stalls in RESP while a new request is offered.
        accept(64'h102, 3'b001, 1'b1);
        step();
        mem_ack   = 1'b0;
        req_valid = 1'b1;
        addr      = 64'h100;
        f3        = 3'b010;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_lv", {63'b0, o_lv}, 64'd1);
            chk("stall_data", o_ld, 64'h0000_0000_FFFF_A14B);
            chk("stall_ready", {63'b0, o_rr}, 64'd0);
            chk("stall_mreq", {63'b0, o_mr}, 64'd0);
        end
        req_valid = 1'b0;
        release_resp("stall");
        step();
        chk("stall_no_accept", {63'b0, o_mr}, 64'd0);

        // Asynchronous reset in the middle of MEM.
        accept(64'h100, 3'b010, 1'b0);
        chk("arst_pre", {63'b0, o_mr}, 64'd1);
        rst = 1'b1;
        #2;
        chk("arst_mreq", {63'b0, o_mr}, 64'd0);
        chk("arst_maddr", o_ma, 64'd0);
        chk("arst_lv", {63'b0, o_lv}, 64'd0);
        chk("arst_data", o_ld, 64'd0);
        chk("arst_ready", {63'b0, o_rr}, 64'd1);
        rst = 1'b0;
        zero_wait("post_rst_lb", 64'h101, 3'b000, 64'h0000_0000_FFFF_FFC5);

        sel64 = 1'b1;
        zero_wait("ld8", 64'h8, 3'b011, 64'hFEDC_BA98_A14B_C5F3);
        zero_wait("lwu_c", 64'hC, 3'b110, 64'h0000_0000_FEDC_BA98);
        zero_wait("lw_c", 64'hC, 3'b010, 64'hFFFF_FFFF_FEDC_BA98);
        zero_wait("lb_e", 64'hE, 3'b000, 64'hFFFF_FFFF_FFFF_FFDC);
        mis_check("f3_111", 64'h8, 3'b111);
        mis_check("ld_c", 64'hC, 3'b011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
